// File: rtl/pack_sched.sv
// Round-robin arbiter and sequencer in front of the shared posit packing stage:
// grants one of two requesters, tracks the packing latency and buffers packed words.
module pack_sched #(
  parameter int PACK_LAT   = 1,
  parameter int OBUF_DEPTH = 2,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_pre,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_pre,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             pk_sel,
  output logic [1:0]       pk_pre,
  input  logic [31:0]      pk_result,
  input  logic             flush,
  output logic             flush_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [1:0]       out_pre,
  output logic             out_src,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam int CW = $clog2(OBUF_DEPTH + 1);
  localparam int PW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam int EW = 1 + 1 + 2 + TAG_W + 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic            rr_last_reg, rr_last_next;
  logic            live_reg;
  logic            flush_seen_reg, flush_seen_next;
  logic [CW-1:0]   credit_reg, credit_next;

  logic            any_valid, issue_ok, issue, grant;
  logic [1:0]      sel_pre;
  logic [TAG_W-1:0] sel_tag;

  logic            pv_reg [PACK_LAT];
  logic            ps_reg [PACK_LAT];
  logic            pe_reg [PACK_LAT];
  logic [1:0]      pp_reg [PACK_LAT];
  logic [TAG_W-1:0] pt_reg [PACK_LAT];
  logic            pipe_empty;

  logic [EW-1:0]   mem [OBUF_DEPTH];
  logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg, count_next;
  logic            wr_en, pop, all_empty;
  logic [EW-1:0]   wr_word, head_word;

  // Arbitration: ready is combinational from the valids, gated by state and credit.
  always_comb begin
    any_valid  = req0_valid | req1_valid;
    issue_ok   = live_reg && (state_reg != DRAIN) && !flush && (credit_reg != '0);
    grant      = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~rr_last_reg;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
    issue      = issue_ok & any_valid;
    req0_ready = issue & ~grant;
    req1_ready = issue & grant;
    sel_pre    = grant ? req1_pre : req0_pre;
    sel_tag    = grant ? req1_tag : req0_tag;
    pk_sel     = issue & grant;
    pk_pre     = (issue && (sel_pre != 2'b11)) ? sel_pre : 2'b00;
    rr_last_next = issue ? grant : rr_last_reg;
  end

  // Tracking pipe mirrors the packing datapath latency.
  generate
    for (genvar gi = 0; gi < PACK_LAT; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            pv_reg[0] <= 1'b0;
            ps_reg[0] <= 1'b0;
            pe_reg[0] <= 1'b0;
            pp_reg[0] <= 2'b00;
            pt_reg[0] <= '0;
          end else begin
            pv_reg[0] <= issue;
            ps_reg[0] <= grant;
            pe_reg[0] <= (sel_pre == 2'b11);
            pp_reg[0] <= sel_pre;
            pt_reg[0] <= sel_tag;
          end
        end
      end else begin : g_tail
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            pv_reg[gi] <= 1'b0;
            ps_reg[gi] <= 1'b0;
            pe_reg[gi] <= 1'b0;
            pp_reg[gi] <= 2'b00;
            pt_reg[gi] <= '0;
          end else begin
            pv_reg[gi] <= pv_reg[gi-1];
            ps_reg[gi] <= ps_reg[gi-1];
            pe_reg[gi] <= pe_reg[gi-1];
            pp_reg[gi] <= pp_reg[gi-1];
            pt_reg[gi] <= pt_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  always_comb begin
    pipe_empty = 1'b1;
    for (int i = 0; i < PACK_LAT; i++) begin
      if (pv_reg[i]) pipe_empty = 1'b0;
    end
  end

  // Output FIFO; illegal-precision entries carry a zero word instead of pk_result.
  always_comb begin
    wr_en     = pv_reg[PACK_LAT-1];
    wr_word   = {pe_reg[PACK_LAT-1], ps_reg[PACK_LAT-1], pp_reg[PACK_LAT-1],
                 pt_reg[PACK_LAT-1], (pe_reg[PACK_LAT-1] ? 32'h0 : pk_result)};
    out_valid = (count_reg != '0);
    pop       = out_valid & out_ready;
    head_word = mem[rd_ptr_reg];
    {out_err, out_src, out_pre, out_tag, out_data} = out_valid ? head_word : '0;
    all_empty = pipe_empty && (count_reg == '0);

    count_next = count_reg;
    if (wr_en && !pop) begin
      count_next = count_reg + 1'b1;
    end else if (pop && !wr_en) begin
      count_next = count_reg - 1'b1;
    end

    credit_next = credit_reg;
    if (issue && !pop) begin
      credit_next = credit_reg - 1'b1;
    end else if (pop && !issue) begin
      credit_next = credit_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= wr_word;
  end

  // Flow control FSM; flush_done fires once per flush assertion.
  always_comb begin
    state_next = state_reg;
    flush_done = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (flush) begin
          if (all_empty) begin
            flush_done = ~flush_seen_reg;
          end else begin
            state_next = DRAIN;
          end
        end else if (any_valid) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (flush) begin
          state_next = DRAIN;
        end else if (!any_valid && pipe_empty) begin
          state_next = IDLE;
        end
      end
      DRAIN: begin
        if (all_empty) begin
          flush_done = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    flush_seen_next = flush_seen_reg;
    if (!flush) begin
      flush_seen_next = 1'b0;
    end else if (flush_done) begin
      flush_seen_next = 1'b1;
    end
  end

  // flush_seen resets high so a flush held through reset does not report a drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      rr_last_reg    <= 1'b1;
      live_reg       <= 1'b0;
      flush_seen_reg <= 1'b1;
      credit_reg     <= CW'(OBUF_DEPTH);
      count_reg      <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
    end else begin
      state_reg      <= state_next;
      rr_last_reg    <= rr_last_next;
      live_reg       <= 1'b1;
      flush_seen_reg <= flush_seen_next;
      credit_reg     <= credit_next;
      count_reg      <= count_next;
      if (wr_en) begin
        wr_ptr_reg <= (wr_ptr_reg == PW'(OBUF_DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= (rd_ptr_reg == PW'(OBUF_DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
      end
    end
  end

endmodule
